// File: rtl/cr_dequantizer.sv
// ============================================================================
// Module      : cr_dequantizer
// Description : Rebuilds Cr DCT coefficients from one 8x8 block of quantized
//               values, Z = sat11(Q * Q_MATRIX), one coefficient per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cr_dequantizer #(
    parameter int Q_MATRIX [8][8] = '{
        '{17, 18, 24, 47, 99, 99, 99, 99},
        '{18, 21, 26, 66, 99, 99, 99, 99},
        '{24, 26, 56, 99, 99, 99, 99, 99},
        '{47, 66, 99, 99, 99, 99, 99, 99},
        '{99, 99, 99, 99, 99, 99, 99, 99},
        '{99, 99, 99, 99, 99, 99, 99, 99},
        '{99, 99, 99, 99, 99, 99, 99, 99},
        '{99, 99, 99, 99, 99, 99, 99, 99}
    }
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic signed [10:0] Q [8][8],
    output logic signed [10:0] Z [8][8],
    output logic               out_enable,
    output logic               busy
);

    localparam logic [5:0]          c_IDX_LAST = 6'd63;
    localparam logic signed [19:0]  c_SAT_MAX  = 20'sd1023;
    localparam logic signed [19:0]  c_SAT_MIN  = -20'sd1024;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               out_enable_q, out_enable_d;
    logic signed [10:0] qb_q [64];
    logic signed [10:0] qb_d [64];
    logic signed [10:0] z_q  [64];
    logic signed [10:0] z_d  [64];

    logic [7:0]         w_rom    [64];
    logic signed [10:0] w_q_flat [64];
    logic signed [10:0] w_qval;
    logic [7:0]         w_step;
    logic signed [19:0] w_qext;
    logic signed [19:0] w_sext;
    logic signed [19:0] w_prod;
    logic signed [10:0] w_sat;

    // Step table and row-major flattening of the 2-D ports.
    for (genvar gi = 0; gi < 64; gi++) begin : g_flat
        assign w_rom[gi]    = 8'(Q_MATRIX[gi / 8][gi % 8]);
        assign w_q_flat[gi] = Q[gi / 8][gi % 8];
        assign Z[gi / 8][gi % 8] = z_q[gi];
    end

    // Single shared multiplier; the step is unsigned so it is zero-extended.
    assign w_qval = qb_q[idx_q];
    assign w_step = w_rom[idx_q];
    assign w_qext = {{9{w_qval[10]}}, w_qval};
    assign w_sext = {12'd0, w_step};
    assign w_prod = w_qext * w_sext;

    always_comb begin
        if (w_prod > c_SAT_MAX) begin
            w_sat = 11'sd1023;
        end else if (w_prod < c_SAT_MIN) begin
            w_sat = -11'sd1024;
        end else begin
            w_sat = w_prod[10:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        out_enable_d = 1'b0;
        qb_d         = qb_q;
        z_d          = z_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    qb_d    = w_q_flat;
                    idx_d   = 6'd0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                z_d[idx_q] = w_sat;
                idx_d      = idx_q + 6'd1;
                if (idx_q == c_IDX_LAST) begin
                    out_enable_d = 1'b1;
                    busy_d       = 1'b0;
                    idx_d        = 6'd0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                idx_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 6'd0;
            busy_q       <= 1'b0;
            out_enable_q <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                qb_q[i] <= 11'sd0;
                z_q[i]  <= 11'sd0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            out_enable_q <= out_enable_d;
            qb_q         <= qb_d;
            z_q          <= z_d;
        end
    end

    assign out_enable = out_enable_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cr_dequantizer.sv
// ============================================================================
// Module      : tb_cr_dequantizer
// Description : Directed self-checking bench for cr_dequantizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cr_dequantizer;

    localparam int c_ONES [8][8] = '{default: '{default: 1}};

    logic               clk = 1'b0;
    logic               rst;
    logic               en0, en1;
    logic signed [10:0] q  [8][8];
    logic signed [10:0] z0 [8][8];
    logic signed [10:0] z1 [8][8];
    logic               oe0, oe1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int qe [8][8];

    cr_dequantizer u_dut (
        .clk(clk), .rst(rst), .enable(en0), .Q(q),
        .Z(z0), .out_enable(oe0), .busy(busy0)
    );

    cr_dequantizer #(.Q_MATRIX(c_ONES)) u_dut_ones (
        .clk(clk), .rst(rst), .enable(en1), .Q(q),
        .Z(z1), .out_enable(oe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int std_step(input int r, input int c);
        int row0 [8] = '{17, 18, 24, 47, 99, 99, 99, 99};
        int row1 [8] = '{18, 21, 26, 66, 99, 99, 99, 99};
        int row2 [8] = '{24, 26, 56, 99, 99, 99, 99, 99};
        int row3 [8] = '{47, 66, 99, 99, 99, 99, 99, 99};
        case (r)
            0: return row0[c];
            1: return row1[c];
            2: return row2[c];
            3: return row3[c];
            default: return 99;
        endcase
    endfunction

    function automatic int sat11(input int p);
        if (p > 1023) return 1023;
        if (p < -1024) return -1024;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                qe[r][c] = int'(q[r][c]);
    endtask

    task automatic set_q_all(input int v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                q[r][c] = 11'(v);
    endtask

    task automatic pulse(input bit sel);
        if (sel) en1 = 1'b1; else en0 = 1'b1;
        step();
        en0 = 1'b0;
        en1 = 1'b0;
    endtask

    // Cycles from the accepting edge to the first sampled out_enable.
    task automatic wait_done(input bit sel, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!(sel ? oe1 : oe0) && lat < 200);
    endtask

    task automatic check_z(input bit sel, input bit ones, input string tag);
        int got, exp;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                got = sel ? int'(z1[r][c]) : int'(z0[r][c]);
                exp = ones ? qe[r][c] : sat11(qe[r][c] * std_step(r, c));
                chk($sformatf("%s_z[%0d][%0d]", tag, r, c), got, exp);
            end
    endtask

    initial begin
        int lat, k, npulse, first, nz;
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        set_q_all(0);
        step();
        step();
        rst = 1'b0;

        chk("rst_busy", int'(busy0), 0);
        chk("rst_oe", int'(oe0), 0);
        chk("rst_z00", int'(z0[0][0]), 0);
        chk("rst_z77", int'(z0[7][7]), 0);

        // 1: identity table
        k = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if (r + c < 7) begin
                    q[r][c] = 11'(200 + k);
                    k++;
                end else if (r + c == 7) begin
                    q[r][c] = 11'sd50;
                end else begin
                    q[r][c] = 11'(((r * 8 + c) % 3) - 1);
                end
            end
        snap();
        pulse(1'b1);
        chk("t1_busy", int'(busy1), 1);
        wait_done(1'b1, lat);
        chk("t1_latency", lat, 64);
        chk("t1_z00", int'(z1[0][0]), 200);
        chk("t1_z06", int'(z1[0][6]), 206);
        check_z(1'b1, 1'b1, "t1");
        step();
        chk("t1_oe_width", int'(oe1), 0);

        // 2: default table, sparse block
        set_q_all(0);
        q[0][0] = 11'sd10;
        q[7][7] = -11'sd3;
        snap();
        pulse(1'b0);
        wait_done(1'b0, lat);
        chk("t2_latency", lat, 64);
        chk("t2_z00", int'(z0[0][0]), 170);
        chk("t2_z77", int'(z0[7][7]), -297);
        check_z(1'b0, 1'b0, "t2");

        // 3: saturation
        set_q_all(0);
        q[7][7] = 11'sd100;
        q[7][6] = -11'sd100;
        q[0][0] = 11'sd60;
        snap();
        pulse(1'b0);
        wait_done(1'b0, lat);
        chk("t3_z77_pos", int'(z0[7][7]), 1023);
        chk("t3_z76_neg", int'(z0[7][6]), -1024);
        chk("t3_z00", int'(z0[0][0]), 1020);
        check_z(1'b0, 1'b0, "t3");

        // 4: enable and Q change while busy
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                q[r][c] = 11'(r * 8 + c - 32);
        snap();
        pulse(1'b0);
        npulse = 0;
        first  = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            en0 = 1'b0;
            if (oe0) begin
                npulse++;
                if (first == 0) first = i;
            end
            if (i == 30) begin
                en0 = 1'b1;
                set_q_all(5);
            end
        end
        chk("t4_first_oe", first, 64);
        chk("t4_pulses", npulse, 1);
        chk("t4_z00", int'(z0[0][0]), -544);
        check_z(1'b0, 1'b0, "t4");

        // 5: reset mid-block
        set_q_all(-7);
        snap();
        pulse(1'b0);
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", int'(busy0), 0);
        chk("t5_oe", int'(oe0), 0);
        nz = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (z0[r][c] != 0) nz++;
        chk("t5_z_nonzero", nz, 0);
        npulse = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (oe0) npulse++;
        end
        chk("t5_no_oe", npulse, 0);
        pulse(1'b0);
        wait_done(1'b0, lat);
        chk("t5_latency", lat, 64);
        chk("t5_z77", int'(z0[7][7]), -693);
        check_z(1'b0, 1'b0, "t5");

        // 6: back-to-back blocks
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                q[r][c] = 11'(c - r);
        snap();
        pulse(1'b0);
        wait_done(1'b0, lat);
        chk("t6a_latency", lat, 64);
        check_z(1'b0, 1'b0, "t6a");
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                q[r][c] = 11'(3 * r - c + 1);
        snap();
        pulse(1'b0);
        chk("t6_busy", int'(busy0), 1);
        chk("t6_oe_drop", int'(oe0), 0);
        wait_done(1'b0, lat);
        chk("t6b_latency", lat, 64);
        chk("t6b_z00", int'(z0[0][0]), 17);
        check_z(1'b0, 1'b0, "t6b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
